// File: rtl/control_displays_bcd.sv
// Sequential binary-to-BCD converter (iterative shift-add-3) with a one-deep request queue
// and a time-multiplexed 3-digit 7-segment scanner with leading-zero blanking.
module control_displays_bcd #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [8:0] VALOR,
  input  logic       CARGAR,
  output logic       OCUPADO,
  output logic       LISTO,
  output logic [3:0] CENTENAS,
  output logic [3:0] DECENAS,
  output logic [3:0] UNIDADES,
  output logic [2:0] ANODOS,
  output logic [3:0] DIGITO,
  output logic [6:0] SEG
);

  localparam int unsigned RefW = $clog2(REFRESH_DIV);
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

  state_e          state_q, state_d;
  logic [20:0]     sr_q, sr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [8:0]      pend_val_q, pend_val_d;
  logic [3:0]      cent_q, cent_d, dec_q, dec_d, uni_q, uni_d;
  logic            listo_q, listo_d;
  logic [RefW-1:0] ref_q, ref_d;
  logic [1:0]      idx_q, idx_d;

  // Layout: [20:17] hundreds, [16:13] tens, [12:9] units, [8:0] binary still to shift in.
  function automatic logic [20:0] dabble(input logic [20:0] s);
    logic [20:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[9+4*i +: 4] >= 4'd5) t[9+4*i +: 4] = t[9+4*i +: 4] + 4'd3;
    end
    return {t[19:0], 1'b0};
  endfunction

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    cent_d     = cent_q;
    dec_d      = dec_q;
    uni_d      = uni_q;
    listo_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (CARGAR) begin
          sr_d    = {12'b0, VALOR};
          cnt_d   = 4'd8;
          state_d = StConv;
        end
      end
      StConv: begin
        sr_d = dabble(sr_q);
        if (cnt_q == 4'd0) state_d = StCommit;
        else               cnt_d   = cnt_q - 4'd1;
        if (CARGAR) begin
          pend_d     = 1'b1;
          pend_val_d = VALOR;
        end
      end
      StCommit: begin
        cent_d  = sr_q[20:17];
        dec_d   = sr_q[16:13];
        uni_d   = sr_q[12:9];
        listo_d = 1'b1;
        if (CARGAR) begin
          sr_d    = {12'b0, VALOR};
          cnt_d   = 4'd8;
          state_d = StConv;
        end else if (pend_q) begin
          sr_d    = {12'b0, pend_val_q};
          cnt_d   = 4'd8;
          pend_d  = 1'b0;
          state_d = StConv;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan runs free of the FSM and only ever reads committed digits.
  always_comb begin
    ref_d = (ref_q == RefLast) ? '0 : ref_q + RefW'(1);
    idx_d = idx_q;
    if (ref_q == RefLast) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      cent_q     <= '0;
      dec_q      <= '0;
      uni_q      <= '0;
      listo_q    <= 1'b0;
      ref_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      cent_q     <= cent_d;
      dec_q      <= dec_d;
      uni_q      <= uni_d;
      listo_q    <= listo_d;
      ref_q      <= ref_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    unique case (idx_q)
      2'd1:    begin
        DIGITO = dec_q;
        ANODOS = (cent_q == 4'd0 && dec_q == 4'd0) ? 3'b111 : 3'b101;
      end
      2'd2:    begin
        DIGITO = cent_q;
        ANODOS = (cent_q == 4'd0) ? 3'b111 : 3'b011;
      end
      default: begin
        DIGITO = uni_q;
        ANODOS = 3'b110;
      end
    endcase
  end

  always_comb begin
    unique case (DIGITO)
      4'd0:    SEG = 7'b1000000;
      4'd1:    SEG = 7'b1111001;
      4'd2:    SEG = 7'b0100100;
      4'd3:    SEG = 7'b0110000;
      4'd4:    SEG = 7'b0011001;
      4'd5:    SEG = 7'b0010010;
      4'd6:    SEG = 7'b0000010;
      4'd7:    SEG = 7'b1111000;
      4'd8:    SEG = 7'b0000000;
      4'd9:    SEG = 7'b0010000;
      default: SEG = 7'b1111111;
    endcase
  end

  assign OCUPADO  = (state_q != StIdle);
  assign LISTO    = listo_q;
  assign CENTENAS = cent_q;
  assign DECENAS  = dec_q;
  assign UNIDADES = uni_q;

endmodule

// File: tb/tb_control_displays_bcd.sv
// Directed bench for control_displays_bcd: conversion table, latency, pending queue,
// reset mid-conversion and digit scanning with blanking.
module tb_control_displays_bcd;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] valor;
  logic       cargar;
  logic       ocupado, listo;
  logic [3:0] cent, dec, uni, digito;
  logic [2:0] anodos;
  logic [6:0] seg;

  int n_cmp = 0;
  int n_bad = 0;

  control_displays_bcd #(.REFRESH_DIV(4)) dut (
    .CLK(clk), .RESET_N(rst_n), .VALOR(valor), .CARGAR(cargar),
    .OCUPADO(ocupado), .LISTO(listo), .CENTENAS(cent), .DECENAS(dec), .UNIDADES(uni),
    .ANODOS(anodos), .DIGITO(digito), .SEG(seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] v;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] u;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Issues one request; lat = edges from the sampling edge to LISTO visible,
  // busy = cycles OCUPADO was seen high before that.
  task automatic convert(input logic [8:0] v, output int lat, output int busy);
    @(negedge clk);
    valor  = v;
    cargar = 1'b1;
    @(posedge clk);
    #1 cargar = 1'b0;
    lat  = 0;
    busy = 0;
    while (!listo && lat < 40) begin
      if (ocupado) busy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " ocupado"}, int'(ocupado), 0);
    chk({tag, " listo"}, int'(listo), 0);
    chk({tag, " digits"}, int'({cent, dec, uni}), 0);
    chk({tag, " anodos"}, int'(anodos), 3'b110);
    chk({tag, " digito"}, int'(digito), 0);
    chk({tag, " seg"}, int'(seg), 7'b1000000);
  endtask

  // Aligns to the start of the units slot, then checks 3 slots of 4 cycles each.
  task automatic scan_check(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [2:0] a0, input logic [2:0] a1,
                            input logic [2:0] a2);
    logic [2:0] prev;
    logic [3:0] ed;
    logic [2:0] ea;
    int         k;
    k    = 0;
    prev = anodos;
    @(posedge clk);
    #1;
    while (!(anodos == 3'b110 && prev != 3'b110) && k < 20) begin
      prev = anodos;
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, " sync"}, int'(k < 20), 1);
    for (int i = 0; i < 12; i++) begin
      ed = (i < 4) ? d0 : (i < 8) ? d1 : d2;
      ea = (i < 4) ? a0 : (i < 8) ? a1 : a2;
      chk($sformatf("%s anodos c%0d", tag, i), int'(anodos), int'(ea));
      chk($sformatf("%s digito c%0d", tag, i), int'(digito), int'(ed));
      chk($sformatf("%s seg c%0d", tag, i), int'(seg), int'(seg_of(ed)));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   lat, busy, nl;
    int   lk[2];
    int   ld[2];

    vecs[0] = '{v: 9'd511, c: 4'd5, d: 4'd1, u: 4'd1};
    vecs[1] = '{v: 9'd255, c: 4'd2, d: 4'd5, u: 4'd5};
    vecs[2] = '{v: 9'd100, c: 4'd1, d: 4'd0, u: 4'd0};
    vecs[3] = '{v: 9'd9,   c: 4'd0, d: 4'd0, u: 4'd9};
    vecs[4] = '{v: 9'd0,   c: 4'd0, d: 4'd0, u: 4'd0};
    vecs[5] = '{v: 9'd305, c: 4'd3, d: 4'd0, u: 4'd5};
    vecs[6] = '{v: 9'd99,  c: 4'd0, d: 4'd9, u: 4'd9};
    vecs[7] = '{v: 9'd480, c: 4'd4, d: 4'd8, u: 4'd0};

    rst_n  = 1'b0;
    valor  = '0;
    cargar = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("init");
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      convert(vecs[i].v, lat, busy);
      chk($sformatf("v%0d latency", vecs[i].v), lat, 10);
      chk($sformatf("v%0d busy", vecs[i].v), busy, 10);
      chk($sformatf("v%0d cent", vecs[i].v), int'(cent), int'(vecs[i].c));
      chk($sformatf("v%0d dec", vecs[i].v), int'(dec), int'(vecs[i].d));
      chk($sformatf("v%0d uni", vecs[i].v), int'(uni), int'(vecs[i].u));
      chk($sformatf("v%0d ocupado@listo", vecs[i].v), int'(ocupado), 0);
      @(posedge clk);
      #1 chk($sformatf("v%0d listo width", vecs[i].v), int'(listo), 0);
    end

    // Pending: 123 at t, 45 at t+3, 300 at t+5; 45 is overwritten.
    @(negedge clk);
    valor  = 9'd123;
    cargar = 1'b1;
    nl     = 0;
    lk     = '{0, 0};
    ld     = '{0, 0};
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      cargar = (k == 3 || k == 5);
      valor  = (k == 3) ? 9'd45 : (k == 5) ? 9'd300 : 9'd0;
      @(posedge clk);
      #1;
      if (listo) begin
        if (nl < 2) begin
          lk[nl] = k;
          ld[nl] = int'({cent, dec, uni});
        end
        nl++;
      end
    end
    cargar = 1'b0;
    chk("pend listo count", nl, 2);
    chk("pend first edge", lk[0], 10);
    chk("pend first digits", ld[0], 12'h123);
    chk("pend second edge", lk[1], 20);
    chk("pend second digits", ld[1], 12'h300);

    // Reset during conversion with a pending request queued.
    convert(9'd255, lat, busy);
    @(negedge clk);
    valor  = 9'd511;
    cargar = 1'b1;
    @(posedge clk);
    #1 valor = 9'd77;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cargar = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("midreset");
    @(negedge clk) rst_n = 1'b1;
    nl = 0;
    busy = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (listo) nl++;
      if (ocupado) busy++;
    end
    chk("midreset no listo", nl, 0);
    chk("midreset no busy", busy, 0);

    convert(9'd7, lat, busy);
    chk("scan7 digits", int'({cent, dec, uni}), 12'h007);
    scan_check("scan7", 4'd7, 4'd0, 4'd0, 3'b110, 3'b111, 3'b111);

    convert(9'd305, lat, busy);
    chk("scan305 digits", int'({cent, dec, uni}), 12'h305);
    scan_check("scan305", 4'd5, 4'd0, 4'd3, 3'b110, 3'b101, 3'b011);

    convert(9'd40, lat, busy);
    scan_check("scan40", 4'd0, 4'd4, 4'd0, 3'b110, 3'b101, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
